ssd_scan_controller: RTL

Time-multiplexes one shared seven-segment cathode bus across `DIGITS` common-anode digits on the board display. It replaces any derived-clock scanning with a single-clock, clock-enable-style slot scheduler. It double-buffers the displayed hexadecimal value so frames never tear, and it inserts a blanking interval between digits to suppress ghosting. It sits between the BCD/hex value producers and the SSD pins.

---
 rtl/ssd_scan_controller.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_controller.sv
// Seven-segment scan controller: one shared cathode bus multiplexed across DIGITS
// common-anode digits, with a double-buffered value and a blanking gap at the start of each slot.
module ssd_scan_controller #(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000,
  parameter int BLANK  = 1000,
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic [DIGITS-1:0]     Dp,
  input  logic                  Lzb_En,
  output logic [DIGITS-1:0]     An,
  output logic [6:0]            Seg,
  output logic                  Dp_N,
  output logic [IDX_W-1:0]      Digit_Idx,
  output logic                  Loaded,
  output logic                  Frame_Done
);

  // state    | meaning
  // ST_IDLE  | display dark, counter and digit index held at 0
  // ST_BLANK | first BLANK cycles of a slot, all anodes off
  // ST_ON    | remaining cycles of the slot, digit Digit_Idx lit
  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_ON} state_e;

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0]   act_val_q, act_val_d;
  logic [DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic                  loaded_q, loaded_d;
  logic                  frame_done_q, frame_done_d;
  logic                  boundary, wrap;
  logic [DIGITS-1:0]     lz;
  logic [3:0]            nib;
  logic                  dp_sel, blank_lz;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      loaded_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      loaded_q     <= loaded_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    wrap     = 1'b0;
    if (!Enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          idx_d    = '0;
          boundary = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BLANK - 1)) state_d = ST_ON;
        end
        ST_ON: begin
          if (cnt_q == CNT_W'(DIV - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
              idx_d    = '0;
              wrap     = 1'b1;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A Load coinciding with the frame boundary bypasses the pending buffer entirely.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    loaded_d     = 1'b0;
    frame_done_d = wrap;
    if (Load) begin
      pend_val_d   = Value;
      pend_dp_d    = Dp;
      pend_valid_d = 1'b1;
    end
    if (boundary) begin
      if (Load) begin
        act_val_d    = Value;
        act_dp_d     = Dp;
        pend_valid_d = 1'b0;
        loaded_d     = 1'b1;
      end else if (pend_valid_q) begin
        act_val_d    = pend_val_q;
        act_dp_d     = pend_dp_q;
        pend_valid_d = 1'b0;
        loaded_d     = 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the FSM.
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (act_val_q[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = (act_val_q[4*i +: 4] == 4'h0) && lz[i+1];
    end
    nib      = '0;
    dp_sel   = 1'b0;
    blank_lz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib      = act_val_q[4*i +: 4];
        dp_sel   = act_dp_q[i];
        blank_lz = Lzb_En && lz[i] && (i != 0);
      end
    end
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    if (state_d == ST_ON) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) an_d[i] = 1'b0;
      end
      seg_d  = blank_lz ? 7'h7F : hex_to_seg(nib);
      dp_n_d = ~dp_sel;
    end
  end

  assign An         = an_q;
  assign Seg        = seg_q;
  assign Dp_N       = dp_n_q;
  assign Digit_Idx  = idx_q;
  assign Loaded     = loaded_q;
  assign Frame_Done = frame_done_q;

endmodule
